// File: rtl/directory_mem_arbiter.sv
// directory_mem_arbiter: round-robin share of one memory port among directory slices, one transaction in flight
module directory_mem_arbiter #(
  parameter int N_PORTS      = 4,
  parameter int PORT_BITS    = 2,
  parameter int MSG_BITS     = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int CACHE_WIDTH  = 128,
  parameter int NO_REQ       = 0,
  parameter int WB_REQ       = 1,
  parameter int R_REQ        = 2,
  parameter int MEM_RESP     = 5
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [N_PORTS*MSG_BITS-1:0]       i_dir_msg_in,
  input  logic [N_PORTS*ADDRESS_BITS-1:0]   i_dir_address_in,
  input  logic [N_PORTS*CACHE_WIDTH-1:0]    i_dir_data_in,
  output logic [N_PORTS*MSG_BITS-1:0]       o_dir_msg_out,
  output logic [N_PORTS*ADDRESS_BITS-1:0]   o_dir_address_out,
  output logic [N_PORTS*CACHE_WIDTH-1:0]    o_dir_data_out,
  output logic [MSG_BITS-1:0]               o_mem_msg_out,
  output logic [ADDRESS_BITS-1:0]           o_mem_address_out,
  output logic [CACHE_WIDTH-1:0]            o_mem_data_out,
  input  logic [MSG_BITS-1:0]               i_mem_msg_in,
  input  logic [ADDRESS_BITS-1:0]           i_mem_address_in,
  input  logic [CACHE_WIDTH-1:0]            i_mem_data_in
);
  localparam logic [MSG_BITS-1:0] L_NO   = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] L_WB   = MSG_BITS'(WB_REQ);
  localparam logic [MSG_BITS-1:0] L_RD   = MSG_BITS'(R_REQ);
  localparam logic [MSG_BITS-1:0] L_RESP = MSG_BITS'(MEM_RESP);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  state_t                           r_state, w_state_n;
  logic [PORT_BITS-1:0]             r_ptr, r_grant, w_pick, w_idx, w_ptr_n;
  logic [ADDRESS_BITS-1:0]          r_addr;
  logic [CACHE_WIDTH-1:0]           r_rdata;
  logic [MSG_BITS-1:0]              r_mem_msg, w_mem_msg_n;
  logic [ADDRESS_BITS-1:0]          r_mem_addr, w_mem_addr_n;
  logic [CACHE_WIDTH-1:0]           r_mem_data, w_mem_data_n;
  logic [N_PORTS*MSG_BITS-1:0]      r_dir_msg, w_dir_msg_n;
  logic [N_PORTS*ADDRESS_BITS-1:0]  r_dir_addr, w_dir_addr_n;
  logic [N_PORTS*CACHE_WIDTH-1:0]   r_dir_data, w_dir_data_n;
  logic [N_PORTS-1:0]               r_mask, w_elig;
  logic [ADDRESS_BITS-1:0]          r_mask_addr [N_PORTS];
  logic                             w_found, w_hit, w_grant_now, w_hold;
  assign o_mem_msg_out     = r_mem_msg;
  assign o_mem_address_out = r_mem_addr;
  assign o_mem_data_out    = r_mem_data;
  assign o_dir_msg_out     = r_dir_msg;
  assign o_dir_address_out = r_dir_addr;
  assign o_dir_data_out    = r_dir_data;
  // eligibility and first eligible port at or after the round-robin pointer
  always_comb begin
    w_elig  = '0;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int p = 0; p < N_PORTS; p++)
      w_elig[p] = !r_mask[p] && (i_dir_msg_in[p*MSG_BITS +: MSG_BITS] == L_RD || i_dir_msg_in[p*MSG_BITS +: MSG_BITS] == L_WB);
    for (int i = 0; i < N_PORTS; i++) begin
      w_idx = PORT_BITS'((int'(r_ptr) + i) % N_PORTS);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
    w_ptr_n = (w_pick == PORT_BITS'(N_PORTS-1)) ? '0 : w_pick + 1'b1;
    w_hit   = i_mem_msg_in == L_RESP && i_mem_address_in == r_addr;
  end
  // state register
  always_ff @(posedge i_clock)
    r_state <= i_reset ? S_IDLE : w_state_n;
  // next state: grant, wait for the matching response, forward it for one cycle
  always_comb
    w_state_n = (r_state == S_IDLE) ? (w_found ? S_BUSY : S_IDLE) :
                (r_state == S_BUSY) ? (w_hit ? S_RESP : S_BUSY) : S_IDLE;
  // next values of the registered memory-side and slice-side outputs
  always_comb begin
    w_grant_now  = r_state == S_IDLE && w_found;
    w_hold       = r_state == S_BUSY && !w_hit;
    w_mem_msg_n  = w_grant_now ? i_dir_msg_in[w_pick*MSG_BITS +: MSG_BITS] : w_hold ? r_mem_msg : L_NO;
    w_mem_addr_n = w_grant_now ? i_dir_address_in[w_pick*ADDRESS_BITS +: ADDRESS_BITS] : w_hold ? r_mem_addr : '0;
    w_mem_data_n = w_grant_now ? i_dir_data_in[w_pick*CACHE_WIDTH +: CACHE_WIDTH] : w_hold ? r_mem_data : '0;
    w_dir_msg_n  = '0;
    w_dir_addr_n = '0;
    w_dir_data_n = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_dir_msg_n[p*MSG_BITS +: MSG_BITS]             = (r_state == S_RESP && r_grant == PORT_BITS'(p)) ? L_RESP : L_NO;
      w_dir_addr_n[p*ADDRESS_BITS +: ADDRESS_BITS]    = (r_state == S_RESP && r_grant == PORT_BITS'(p)) ? r_addr : '0;
      w_dir_data_n[p*CACHE_WIDTH +: CACHE_WIDTH]      = (r_state == S_RESP && r_grant == PORT_BITS'(p)) ? r_rdata : '0;
    end
  end
  // datapath: latched transaction, outputs, pointer and stale-request masks
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_addr     <= '0;
      r_rdata    <= '0;
      r_mem_msg  <= L_NO;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_dir_msg  <= '0;
      r_dir_addr <= '0;
      r_dir_data <= '0;
      r_mask     <= '0;
      for (int p = 0; p < N_PORTS; p++) r_mask_addr[p] <= '0;
    end else begin
      r_mem_msg  <= w_mem_msg_n;
      r_mem_addr <= w_mem_addr_n;
      r_mem_data <= w_mem_data_n;
      r_dir_msg  <= w_dir_msg_n;
      r_dir_addr <= w_dir_addr_n;
      r_dir_data <= w_dir_data_n;
      if (w_grant_now) begin
        r_grant <= w_pick;
        r_addr  <= w_mem_addr_n;
        r_ptr   <= w_ptr_n;
      end
      if (r_state == S_BUSY && w_hit) r_rdata <= i_mem_data_in;
      for (int p = 0; p < N_PORTS; p++) begin
        if (r_state == S_RESP && r_grant == PORT_BITS'(p)) begin
          r_mask[p]      <= 1'b1;
          r_mask_addr[p] <= r_addr;
        end else if (r_mask[p] && (i_dir_msg_in[p*MSG_BITS +: MSG_BITS] == L_NO ||
                                   i_dir_address_in[p*ADDRESS_BITS +: ADDRESS_BITS] != r_mask_addr[p]))
          r_mask[p] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_directory_mem_arbiter.sv
// tb_directory_mem_arbiter: directed scenarios plus random traffic against a transaction-level reference model
module tb_directory_mem_arbiter;
  localparam int N = 4, MB = 4, AB = 32, CW = 128;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [N*MB-1:0] dmi = '0, dmo;
  logic [N*AB-1:0] dai = '0, dao;
  logic [N*CW-1:0] ddi = '0, ddo;
  logic [MB-1:0] mmo, mmi = '0;
  logic [AB-1:0] mao, mai = '0;
  logic [CW-1:0] mdo, mdi = '0;
  int total = 0, bad = 0;

  directory_mem_arbiter dut (
    .i_clock(clk), .i_reset(rst),
    .i_dir_msg_in(dmi), .i_dir_address_in(dai), .i_dir_data_in(ddi),
    .o_dir_msg_out(dmo), .o_dir_address_out(dao), .o_dir_data_out(ddo),
    .o_mem_msg_out(mmo), .o_mem_address_out(mao), .o_mem_data_out(mdo),
    .i_mem_msg_in(mmi), .i_mem_address_in(mai), .i_mem_data_in(mdi));

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: one transaction in flight, a pending one-cycle reply, per-port stale masks
  int ptr, g;
  bit active, respond;
  bit mask [N];
  logic [AB-1:0] maddr [N];
  logic [AB-1:0] t_addr;
  logic [CW-1:0] t_rdata;
  logic [MB-1:0] e_mm;
  logic [AB-1:0] e_ma;
  logic [CW-1:0] e_md;
  logic [N*MB-1:0] e_dm;
  logic [N*AB-1:0] e_da;
  logic [N*CW-1:0] e_dd;

  task automatic model_edge();
    bit was_resp;
    bit elig [N];
    int q;
    if (rst) begin
      ptr = 0; g = 0; active = 0; respond = 0; t_addr = '0; t_rdata = '0;
      e_mm = '0; e_ma = '0; e_md = '0; e_dm = '0; e_da = '0; e_dd = '0;
      for (int p = 0; p < N; p++) begin mask[p] = 0; maddr[p] = '0; end
      return;
    end
    was_resp = respond;
    e_dm = '0; e_da = '0; e_dd = '0;
    if (was_resp) begin
      e_dm[g*MB +: MB] = 4'd5;
      e_da[g*AB +: AB] = t_addr;
      e_dd[g*CW +: CW] = t_rdata;
    end
    for (int p = 0; p < N; p++)
      elig[p] = !mask[p] && (dmi[p*MB +: MB] == 4'd1 || dmi[p*MB +: MB] == 4'd2);
    for (int p = 0; p < N; p++)
      if (was_resp && p == g) begin mask[p] = 1; maddr[p] = t_addr; end
      else if (mask[p] && (dmi[p*MB +: MB] == 4'd0 || dai[p*AB +: AB] != maddr[p])) mask[p] = 0;
    respond = 0;
    if (active) begin
      if (mmi == 4'd5 && mai == t_addr) begin
        active = 0; respond = 1; t_rdata = mdi;
        e_mm = '0; e_ma = '0; e_md = '0;
      end
    end else begin
      e_mm = '0; e_ma = '0; e_md = '0;
      if (!was_resp)
        for (int k = 0; k < N; k++) begin
          q = (ptr + k) % N;
          if (elig[q]) begin
            g = q; active = 1; ptr = (q + 1) % N;
            e_mm = dmi[q*MB +: MB]; e_ma = dai[q*AB +: AB]; e_md = ddi[q*CW +: CW];
            t_addr = e_ma;
            break;
          end
        end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("mem_msg", mmo, e_mm);
    chk("mem_addr", mao, e_ma);
    chk("mem_data", mdo, e_md);
    chk("dir_msg", dmo, e_dm);
    chk("dir_addr", dao, e_da);
    chk("dir_data", ddo, e_dd);
  endtask

  task automatic set_port(input int p, input logic [MB-1:0] m, input logic [AB-1:0] a, input logic [CW-1:0] d);
    dmi[p*MB +: MB] = m; dai[p*AB +: AB] = a; ddi[p*CW +: CW] = d;
  endtask

  task automatic mem(input logic [MB-1:0] m, input logic [AB-1:0] a, input logic [CW-1:0] d);
    mmi = m; mai = a; mdi = d;
  endtask

  // wait (bounded) for an issued request, then answer it after a short delay
  task automatic serve(input logic [CW-1:0] d);
    int n = 0;
    while (!active && n < 20) begin cyc(); n++; end
    chk("serve_timeout", active, 1'b1);
    cyc();
    mem(4'd5, t_addr, d); cyc();
    mem(4'd0, '0, '0); cyc();
  endtask

  logic [CW-1:0] dval;
  initial begin
    cyc(); cyc();
    chk("reset_mem_msg", mmo, 4'd0);
    chk("reset_dir_msg", dmo, '0);
    rst = 0;
    // single read with a wrong-address response ignored first
    set_port(0, 4'd2, 32'h100, '0);
    cyc();
    chk("t1_req_msg", mmo, 4'd2);
    chk("t1_req_addr", mao, 32'h100);
    cyc();
    mem(4'd5, 32'h200, 128'hdead); cyc();
    chk("t4_held", mmo, 4'd2);
    chk("t4_no_resp", dmo, '0);
    dval = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    mem(4'd5, 32'h100, dval); cyc();
    mem(4'd0, '0, '0); cyc();
    chk("t1_dir_msg", dmo, 16'h0005);
    chk("t1_dir_data", ddo[CW-1:0], dval);
    // port 0 keeps its old request: must not be re-issued
    cyc(); cyc();
    chk("t5_no_reissue", mmo, 4'd0);
    set_port(0, 4'd2, 32'h140, '0); cyc(); cyc();
    chk("t5_new_addr", mao, 32'h140);
    cyc(); mem(4'd5, 32'h140, 128'h5); cyc(); mem(4'd0, '0, '0);
    set_port(0, 4'd0, '0, '0); cyc(); cyc();
    // two simultaneous requesters: lower index after pointer first
    set_port(1, 4'd2, 32'h200, '0);
    set_port(3, 4'd2, 32'h300, '0);
    cyc();
    chk("t2_first", mao, 32'h200);
    cyc(); mem(4'd5, 32'h200, 128'h2); cyc(); mem(4'd0, '0, '0); cyc();
    set_port(1, 4'd0, '0, '0);
    cyc(); cyc();
    chk("t2_second", mao, 32'h300);
    serve(128'h3);
    set_port(3, 4'd0, '0, '0); cyc();
    // writeback carries its data
    set_port(2, 4'd1, 32'h5000_0100, {32'h6, 32'h5, 32'h4, 32'h3});
    cyc();
    chk("t3_wb_data", mdo, {32'h6, 32'h5, 32'h4, 32'h3});
    serve(128'h77);
    set_port(2, 4'd0, '0, '0); cyc();
    // reset during an outstanding transaction aborts it
    set_port(1, 4'd2, 32'h400, '0); cyc(); cyc();
    rst = 1; mem(4'd5, 32'h400, 128'h9); cyc();
    chk("t6_reset_mem", mmo, 4'd0);
    rst = 0; mem(4'd0, '0, '0); set_port(1, 4'd0, '0, '0);
    set_port(0, 4'd2, 32'h500, '0); set_port(2, 4'd2, 32'h600, '0); cyc(); cyc();
    chk("t6_ptr_zero", mao, 32'h500);
    set_port(0, 4'd0, '0, '0); set_port(2, 4'd0, '0, '0);
    cyc(); mem(4'd5, 32'h500, '0); cyc(); mem(4'd0, '0, '0); cyc(); cyc();
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < N; p++)
        if ($urandom_range(0, 5) == 0) begin
          logic [MB-1:0] m;
          logic [AB-1:0] a;
          case ($urandom_range(0, 4)) 0: m = 4'd0; 1: m = 4'd1; 2, 3: m = 4'd2; default: m = 4'd5; endcase
          case ($urandom_range(0, 3)) 0: a = 32'h100; 1: a = 32'h140; 2: a = 32'h200; default: a = $urandom; endcase
          set_port(p, m, a, {$urandom, $urandom, $urandom, $urandom});
        end
      if (active && $urandom_range(0, 2) == 0)
        mem(4'd5, ($urandom_range(0, 3) == 0) ? t_addr ^ 32'h40 : t_addr, {$urandom, $urandom, $urandom, $urandom});
      else
        mem(($urandom_range(0, 7) == 0) ? 4'd5 : 4'($urandom_range(0, 2)), $urandom, {$urandom, $urandom, $urandom, $urandom});
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
